// File: rtl/add_mw_ctrl.sv
// add_mw_ctrl: sequences a multi-word add/subtract, LS word first, through an external N-bit adder.
// Define ADD_MW_CTRL_OVF_EN to add the registered signed-overflow output ovf.
module add_mw_ctrl #(
   parameter int unsigned N     = 8,
   parameter int unsigned WORDS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] x_in,
   input  logic [N-1:0] y_in,
   output logic [N-1:0] add_x,
   output logic [N-1:0] add_y,
   output logic         add_ci,
   input  logic [N-1:0] add_r,
   input  logic         add_co,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] r_out,
   output logic         r_last,
   output logic         busy,
   output logic         done,
   output logic         co_final
`ifdef ADD_MW_CTRL_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LastIdx = CW'(WORDS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic          op_q, op_d;
   logic          out_valid_q, out_valid_d;
   logic [N-1:0]  r_out_q, r_out_d;
   logic          r_last_q, r_last_d;
   logic          co_final_q, co_final_d;
   logic          accept, drain, last_word, start_ok;

   // Subtraction is x + ~y + 1: invert y here, the +1 comes from the preloaded carry.
   assign add_x  = x_in;
   assign add_y  = y_in ^ {N{op_q}};
   assign add_ci = carry_q;

   assign in_ready  = (state_q == StRun) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid_q && out_ready;
   assign last_word = (cnt_q == LastIdx);
   assign start_ok  = (state_q == StIdle) && start;

   assign done      = (state_q == StDrain) && drain && r_last_q;
   assign busy      = (state_q != StIdle);
   assign out_valid = out_valid_q;
   assign r_out     = r_out_q;
   assign r_last    = r_last_q;
   assign co_final  = co_final_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      op_d        = op_q;
      out_valid_d = out_valid_q;
      r_out_d     = r_out_q;
      r_last_d    = r_last_q;
      co_final_d  = co_final_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StRun;
               cnt_d      = '0;
               carry_d    = sub;
               op_d       = sub;
               co_final_d = 1'b0;
            end
         end
         StRun: begin
            if (accept) begin
               if (last_word) begin
                  cnt_d   = '0;
                  state_d = StDrain;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         StDrain: begin
            if (done) begin
               state_d    = StIdle;
               co_final_d = carry_q;
            end
         end
         default: state_d = StIdle;
      endcase

      // A new word reloads the output register even if the old one drains this cycle.
      if (accept) begin
         r_out_d     = add_r;
         carry_d     = add_co;
         out_valid_d = 1'b1;
         r_last_d    = last_word;
      end else if (drain) begin
         out_valid_d = 1'b0;
         r_last_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         op_q        <= 1'b0;
         out_valid_q <= 1'b0;
         r_out_q     <= '0;
         r_last_q    <= 1'b0;
         co_final_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         op_q        <= op_d;
         out_valid_q <= out_valid_d;
         r_out_q     <= r_out_d;
         r_last_q    <= r_last_d;
         co_final_q  <= co_final_d;
      end
   end

`ifdef ADD_MW_CTRL_OVF_EN
   // Overflow of the latest word is kept until the final word drains.
   logic ovf_word_q, ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_word_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         if (accept) begin
            ovf_word_q <= (add_r[N-1] ^ add_x[N-1] ^ add_y[N-1]) ^ add_co;
         end
         if (start_ok) begin
            ovf_q <= 1'b0;
         end else if (done) begin
            ovf_q <= ovf_word_q;
         end
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_mw_ctrl.sv
// Randomized self-checking bench for add_mw_ctrl against a whole-operand arithmetic model.
// Build with ADD_MW_CTRL_OVF_EN defined to also check the ovf output.
module tb_add_mw_ctrl;

   localparam int unsigned N     = 8;
   localparam int unsigned WORDS = 4;
   localparam int unsigned W     = N * WORDS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, sub, in_valid, in_ready;
   logic [N-1:0] x_in, y_in, add_x, add_y, add_r, r_out;
   logic         add_ci, add_co;
   logic         out_valid, out_ready, r_last, busy, done, co_final;
`ifdef ADD_MW_CTRL_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;
   logic last_co  = 1'b0;
   logic last_ovf = 1'b0;

   always #5 clk = ~clk;

   // External combinational adder.
   assign {add_co, add_r} = {1'b0, add_x} + {1'b0, add_y} + {{N{1'b0}}, add_ci};

   add_mw_ctrl #(.N(N), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sub       (sub),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .add_x     (add_x),
      .add_y     (add_y),
      .add_ci    (add_ci),
      .add_r     (add_r),
      .add_co    (add_co),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r_out     (r_out),
      .r_last    (r_last),
      .busy      (busy),
      .done      (done),
      .co_final  (co_final)
`ifdef ADD_MW_CTRL_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag, input logic exp_co, input logic exp_ovf);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_co_final"}, co_final, exp_co);
`ifdef ADD_MW_CTRL_OVF_EN
      check({tag, "_ovf"}, ovf, exp_ovf);
`else
      if (exp_ovf === 1'bx) check({tag, "_ovf_x"}, 0, 1);
`endif
   endtask

   // mode 0: out_ready always high, 1: random out_ready, 2: 3-cycle stall after first result.
   task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic s,
                         input int mode, input bit noise);
      logic [W-1:0] rv;
      logic         exp_co, exp_ovf, exp_ov, exp_ir, exp_done, drain, acc;
      int           wi, ri, stall;
      bit           fin;

      if (s) begin
         rv      = xv - yv;
         exp_co  = (xv >= yv);
         exp_ovf = (xv[W-1] != yv[W-1]) && (rv[W-1] != xv[W-1]);
      end else begin
         rv      = xv + yv;
         exp_co  = ({1'b0, xv} + {1'b0, yv}) > {1'b0, {W{1'b1}}};
         exp_ovf = (xv[W-1] == yv[W-1]) && (rv[W-1] != xv[W-1]);
      end

      @(negedge clk);
      start     = 1'b1;
      sub       = s;
      in_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      x_in      = N'($urandom);
      y_in      = N'($urandom);
      out_ready = 1'b1;
      #1;
      check("start_busy_before", busy, 0);
      @(posedge clk);

      wi = 0; ri = 0; stall = 0; fin = 0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         @(negedge clk);
         exp_ov = (wi > ri);
         unique case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
               if (exp_ov && ri == 0 && stall < 3) begin
                  out_ready = 1'b0;
                  stall++;
               end else begin
                  out_ready = 1'b1;
               end
            end
         endcase
         if (wi < WORDS) begin
            in_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            x_in     = xv[wi*N +: N];
            y_in     = yv[wi*N +: N];
         end else begin
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            x_in     = N'($urandom);
            y_in     = N'($urandom);
         end
         exp_ir   = (wi < WORDS) && (!exp_ov || out_ready);
         drain    = exp_ov && out_ready;
         acc      = in_valid && exp_ir;
         exp_done = drain && (ri == WORDS - 1);
         start    = noise ? (exp_done ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
         sub      = noise ? 1'($urandom_range(0, 1)) : s;
         #1;
         check("busy", busy, 1);
         check("out_valid", out_valid, exp_ov);
         check("in_ready", in_ready, exp_ir);
         check("done", done, exp_done);
         if (exp_ov) begin
            check("r_out", r_out, rv[ri*N +: N]);
            check("r_last", r_last, (ri == WORDS - 1));
         end
         @(posedge clk);
         if (acc) wi++;
         if (drain) ri++;
         if (exp_done) fin = 1;
      end
      if (!fin) check("op_timeout", 0, 1);

      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      #1;
      check_idle_outputs("after_done", exp_co, exp_ovf);
      last_co  = exp_co;
      last_ovf = exp_ovf;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; in_valid = 1'b0;
      x_in = '0; y_in = '0; out_ready = 1'b1;
      #12;
      check_idle_outputs("reset", 0, 0);
      check("reset_r_out", r_out, 0);
      check("reset_r_last", r_last, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 0);
      run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 0, 0);
      run_op(32'h0000_0005, 32'h0000_0003, 1'b1, 0, 0);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2, 0);

      // in_valid while idle must be ignored and co_final must hold.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         x_in     = N'($urandom);
         y_in     = N'($urandom);
         #1;
         check_idle_outputs("idle_in_valid", last_co, last_ovf);
      end
      in_valid = 1'b0;

      // Reset in the middle of an operation after two words are accepted.
      @(negedge clk);
      start = 1'b1; sub = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
         x_in = N'($urandom); y_in = N'($urandom);
         #1;
         check("pre_rst_in_ready", in_ready, 1);
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_reset", 0, 0);
      check("mid_reset_r_out", r_out, 0);
      check("mid_reset_r_last", r_last, 0);
      repeat (2) begin
         @(negedge clk);
         #1;
         check("reset_hold_done", done, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'h0102_0304, 32'h0101_0101, 1'b0, 0, 0);

      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 0);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 0);
      run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1, 1);

      for (int t = 0; t < 30; t++) begin
         logic [W-1:0] xv, yv;
         xv = W'($urandom);
         yv = (t % 7 == 3) ? xv : W'($urandom);
         run_op(xv, yv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
